// File: rtl/autofire_pkg.sv
// Shared definitions for the multi-channel autofire block: channel modes and
// the period/phase width used by every channel.
package autofire_pkg;

    localparam int PERIOD_W = 4;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_AUTO  = 2'd1,
        MODE_LATCH = 2'd2,
        MODE_MASK  = 2'd3
    } mode_e;

    // Terminal phase count for a half-period; a period of 0 behaves like 1.
    function automatic logic [PERIOD_W-1:0] last_phase(input logic [PERIOD_W-1:0] period);
        return (period == '0) ? '0 : period - 1'b1;
    endfunction

endpackage

// File: rtl/autofire_multi_if.sv
// Button and configuration bus between the controller side (master) and the
// autofire block (slave).
interface autofire_multi_if
    import autofire_pkg::*;
#(
    parameter int NCH = 8
) ();

    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0]      btn;
    logic [NCH-1:0]      out;
    logic                cfg_we;
    logic [CH_W-1:0]     cfg_ch;
    logic [1:0]          cfg_mode;
    logic [PERIOD_W-1:0] cfg_period;
    logic [1:0]          cfg_rd_mode;
    logic [PERIOD_W-1:0] cfg_rd_period;

    modport master (
        output btn, cfg_we, cfg_ch, cfg_mode, cfg_period,
        input  out, cfg_rd_mode, cfg_rd_period
    );

    modport slave (
        input  btn, cfg_we, cfg_ch, cfg_mode, cfg_period,
        output out, cfg_rd_mode, cfg_rd_period
    );

endinterface

// File: rtl/autofire_chan.sv
// One button channel: edge detect, per-channel mode/period registers and the
// pass/autofire/latch/mask output logic with one cycle of latency.
module autofire_chan
    import autofire_pkg::*;
#(
    parameter logic [1:0]          DEFAULT_MODE   = 2'd0,
    parameter logic [PERIOD_W-1:0] DEFAULT_PERIOD = 4'd6
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                tick_i,
    input  logic                btn_i,
    input  logic                cfg_we_i,
    input  logic [1:0]          cfg_mode_i,
    input  logic [PERIOD_W-1:0] cfg_period_i,
    output logic                out_o,
    output logic [1:0]          mode_o,
    output logic [PERIOD_W-1:0] period_o
);

    mode_e               mode_q, mode_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] phase_q, phase_d;
    logic                btn_q, btn_q_d;
    logic                latch_q, latch_d;
    logic                out_q, out_d;
    logic                rise;

    assign rise = btn_i & ~btn_q;

    always_comb begin
        mode_d   = mode_q;
        period_d = period_q;
        phase_d  = phase_q;
        btn_q_d  = btn_i;
        latch_d  = latch_q;
        out_d    = out_q;
        if (cfg_we_i) begin
            // Clearing btn_q makes a still-held button look like a fresh press.
            mode_d   = mode_e'(cfg_mode_i);
            period_d = cfg_period_i;
            phase_d  = '0;
            btn_q_d  = 1'b0;
            latch_d  = 1'b0;
            out_d    = 1'b0;
        end else begin
            case (mode_q)
                MODE_PASS: begin
                    out_d   = btn_i;
                    phase_d = '0;
                end
                MODE_AUTO: begin
                    if (!btn_i) begin
                        out_d   = 1'b0;
                        phase_d = '0;
                    end else if (rise) begin
                        out_d   = 1'b1;
                        phase_d = '0;
                    end else if (tick_i) begin
                        if (phase_q == last_phase(period_q)) begin
                            out_d   = ~out_q;
                            phase_d = '0;
                        end else begin
                            phase_d = phase_q + 1'b1;
                        end
                    end
                end
                MODE_LATCH: begin
                    latch_d = rise ? ~latch_q : latch_q;
                    out_d   = latch_d;
                    phase_d = '0;
                end
                MODE_MASK: begin
                    out_d   = 1'b0;
                    phase_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mode_q   <= mode_e'(DEFAULT_MODE);
            period_q <= DEFAULT_PERIOD;
            phase_q  <= '0;
            btn_q    <= 1'b0;
            latch_q  <= 1'b0;
            out_q    <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            period_q <= period_d;
            phase_q  <= phase_d;
            btn_q    <= btn_q_d;
            latch_q  <= latch_d;
            out_q    <= out_d;
        end
    end

    assign out_o    = out_q;
    assign mode_o   = mode_q;
    assign period_o = period_q;

endmodule

// File: rtl/autofire_multi.sv
// Multi-channel turbo block: shared tick source (prescaler or external strobe),
// per-channel autofire logic, config write decode and combinational readback.
module autofire_multi
    import autofire_pkg::*;
#(
    parameter int FREQ           = 37_800_000,
    parameter int NCH            = 8,
    parameter int TICK_SRC       = 0,
    parameter int TICK_HZ        = 120,
    parameter int DEFAULT_MODE   = 0,
    parameter int DEFAULT_PERIOD = 6
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             tick_in,
    autofire_multi_if.slave  bus
);

    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int DIV   = FREQ / TICK_HZ;
    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PRE_W-1:0] presc_q, presc_d;
    logic             presc_wrap;
    logic             tick;

    assign presc_wrap = (presc_q == PRE_W'(DIV - 1));
    assign presc_d    = presc_wrap ? '0 : presc_q + 1'b1;
    assign tick       = (TICK_SRC != 0) ? tick_in : presc_wrap;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    logic [NCH-1:0]      out_w;
    logic [1:0]          mode_w   [NCH];
    logic [PERIOD_W-1:0] period_w [NCH];

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
            logic we;
            // An out-of-range cfg_ch matches no instance, so the write is dropped.
            assign we = bus.cfg_we && (bus.cfg_ch == CH_W'(gi));

            autofire_chan #(
                .DEFAULT_MODE   (2'(DEFAULT_MODE)),
                .DEFAULT_PERIOD (PERIOD_W'(DEFAULT_PERIOD))
            ) u_chan (
                .clk          (clk),
                .resetn       (resetn),
                .tick_i       (tick),
                .btn_i        (bus.btn[gi]),
                .cfg_we_i     (we),
                .cfg_mode_i   (bus.cfg_mode),
                .cfg_period_i (bus.cfg_period),
                .out_o        (out_w[gi]),
                .mode_o       (mode_w[gi]),
                .period_o     (period_w[gi])
            );
        end
    endgenerate

    assign bus.out = out_w;

    logic [1:0]          rd_mode;
    logic [PERIOD_W-1:0] rd_period;

    always_comb begin
        rd_mode   = '0;
        rd_period = '0;
        for (int i = 0; i < NCH; i++) begin
            if (bus.cfg_ch == CH_W'(i)) begin
                rd_mode   = mode_w[i];
                rd_period = period_w[i];
            end
        end
    end

    assign bus.cfg_rd_mode   = rd_mode;
    assign bus.cfg_rd_period = rd_period;

endmodule

// File: tb/tb_autofire_multi.sv
// Bench for autofire_multi: a prescaled-tick instance (4 channels) and an
// external-tick instance (5 channels) checked against a tick-count model.
module tb_autofire_multi;

    localparam int NA = 4;
    localparam int NB = 5;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    logic tick_b = 1'b0;

    always #5 clk = ~clk;

    autofire_multi_if #(.NCH(NA)) ifa ();
    autofire_multi_if #(.NCH(NB)) ifb ();

    autofire_multi #(
        .FREQ(1000), .NCH(NA), .TICK_SRC(0), .TICK_HZ(100),
        .DEFAULT_MODE(0), .DEFAULT_PERIOD(6)
    ) dut_a (
        .clk(clk), .resetn(resetn), .tick_in(1'b0), .bus(ifa.slave)
    );

    autofire_multi #(
        .FREQ(1000), .NCH(NB), .TICK_SRC(1), .TICK_HZ(100),
        .DEFAULT_MODE(1), .DEFAULT_PERIOD(1)
    ) dut_b (
        .clk(clk), .resetn(resetn), .tick_in(tick_b), .bus(ifb.slave)
    );

    typedef struct packed {
        logic [NA-1:0] a;
        logic [NB-1:0] b;
    } exp_t;

    exp_t  sb[$];
    int    total = 0;
    int    bad   = 0;
    string tag   = "reset";

    // Model state, [instance][channel]
    int m_mode  [2][NB];
    int m_per   [2][NB];
    int m_tk    [2][NB];
    bit m_prev  [2][NB];
    bit m_latch [2][NB];
    int a_cnt;

    task automatic check(input string t, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", t, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < NB; c++) begin
                m_mode[d][c]  = (d == 0) ? 0 : 1;
                m_per[d][c]   = (d == 0) ? 6 : 1;
                m_tk[d][c]    = 0;
                m_prev[d][c]  = 1'b0;
                m_latch[d][c] = 1'b0;
            end
        end
        a_cnt = 0;
    endtask

    // Autofire output is derived from ticks seen since the press:
    // it is high during even-numbered groups of P ticks.
    task automatic model_chan(input int d, input int c, input bit b, input bit tick,
                              input bit we, input int wm, input int wp, output bit e);
        int p;
        if (we) begin
            m_mode[d][c]  = wm;
            m_per[d][c]   = wp;
            m_prev[d][c]  = 1'b0;
            m_latch[d][c] = 1'b0;
            m_tk[d][c]    = 0;
            e = 1'b0;
            return;
        end
        p = (m_per[d][c] == 0) ? 1 : m_per[d][c];
        case (m_mode[d][c])
            0: e = b;
            2: begin
                if (b && !m_prev[d][c]) m_latch[d][c] = ~m_latch[d][c];
                e = m_latch[d][c];
            end
            1: begin
                if (!b) begin
                    e = 1'b0;
                end else if (!m_prev[d][c]) begin
                    m_tk[d][c] = 0;
                    e = 1'b1;
                end else begin
                    if (tick) m_tk[d][c]++;
                    e = ((m_tk[d][c] / p) % 2) == 0;
                end
            end
            default: e = 1'b0;
        endcase
        m_prev[d][c] = b;
    endtask

    // Called at a negedge with inputs set; predicts the outputs after the next posedge.
    task automatic cyc();
        exp_t x;
        bit   e;
        bit   tick_a;
        tick_a = (a_cnt % 10) == 9;
        a_cnt++;
        for (int c = 0; c < NA; c++) begin
            model_chan(0, c, ifa.btn[c], tick_a, ifa.cfg_we && (int'(ifa.cfg_ch) == c),
                       int'(ifa.cfg_mode), int'(ifa.cfg_period), e);
            x.a[c] = e;
        end
        for (int c = 0; c < NB; c++) begin
            model_chan(1, c, ifb.btn[c], tick_b, ifb.cfg_we && (int'(ifb.cfg_ch) == c),
                       int'(ifb.cfg_mode), int'(ifb.cfg_period), e);
            x.b[c] = e;
        end
        sb.push_back(x);
        @(negedge clk);
        ifa.cfg_we = 1'b0;
        ifb.cfg_we = 1'b0;
    endtask

    always @(posedge clk) begin
        exp_t x;
        #1;
        if (sb.size() > 0) begin
            x = sb.pop_front();
            check({tag, "_out_a"}, 32'(ifa.out), 32'(x.a));
            check({tag, "_out_b"}, 32'(ifb.out), 32'(x.b));
        end
    end

    task automatic cfg_a(input int ch, input int mode, input int per);
        ifa.cfg_we = 1'b1; ifa.cfg_ch = 2'(ch); ifa.cfg_mode = 2'(mode); ifa.cfg_period = 4'(per);
        cyc();
    endtask

    task automatic rd_check(input bit on_b, input int ch, input int em, input int ep);
        if (on_b) begin
            ifb.cfg_ch = 3'(ch);
            #1;
            check($sformatf("%s_rd_mode_b%0d", tag, ch), 32'(ifb.cfg_rd_mode), em);
            check($sformatf("%s_rd_period_b%0d", tag, ch), 32'(ifb.cfg_rd_period), ep);
        end else begin
            ifa.cfg_ch = 2'(ch);
            #1;
            check($sformatf("%s_rd_mode_a%0d", tag, ch), 32'(ifa.cfg_rd_mode), em);
            check($sformatf("%s_rd_period_a%0d", tag, ch), 32'(ifa.cfg_rd_period), ep);
        end
    endtask

    task automatic rnd_pass_mask();
        ifa.btn[3:2] = 2'($urandom);
    endtask

    initial begin
        ifa.btn = '1; ifa.cfg_we = 1'b0; ifa.cfg_ch = '0; ifa.cfg_mode = '0; ifa.cfg_period = '0;
        ifb.btn = '1; ifb.cfg_we = 1'b0; ifb.cfg_ch = '0; ifb.cfg_mode = '0; ifb.cfg_period = '0;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_out_a", 32'(ifa.out), 0);
        check("reset_out_b", 32'(ifb.out), 0);
        for (int c = 0; c < NA; c++) rd_check(1'b0, c, 0, 6);
        rd_check(1'b1, 0, 1, 1);
        rd_check(1'b1, 5, 0, 0);

        ifa.btn = '0; ifb.btn = '0;
        model_reset();
        @(negedge clk);
        resetn = 1'b1;

        tag = "cfg";
        cfg_a(0, 1, 2);
        cfg_a(1, 2, 0);
        cfg_a(3, 3, 0);

        tag = "auto_latch";
        for (int i = 0; i < 110; i++) begin
            ifa.btn[0] = (i < 100);
            ifa.btn[1] = (i < 30) && ((i % 10) < 5);
            rnd_pass_mask();
            cyc();
        end

        tag = "tick_in";
        ifb.cfg_we = 1'b1; ifb.cfg_ch = 3'd1; ifb.cfg_mode = 2'd1; ifb.cfg_period = 4'd0;
        cyc();
        for (int i = 0; i < 55; i++) begin
            tick_b     = ((i % 7) == 3);
            ifb.btn[0] = (i >= 3) && (i < 45);
            ifb.btn[1] = (i >= 10) && (i < 45);
            if (i == 20) begin
                ifb.cfg_we = 1'b1; ifb.cfg_ch = 3'd5; ifb.cfg_mode = 2'd3; ifb.cfg_period = 4'd9;
            end
            rnd_pass_mask();
            cyc();
        end
        tick_b = 1'b0;
        rd_check(1'b1, 5, 0, 0);
        rd_check(1'b1, 0, 1, 1);
        rd_check(1'b1, 1, 1, 0);

        tag = "reconfig";
        for (int i = 0; i < 100; i++) begin
            ifa.btn[0] = (i < 90);
            if (i == 15) begin
                ifa.cfg_we = 1'b1; ifa.cfg_ch = 2'd0; ifa.cfg_mode = 2'd1; ifa.cfg_period = 4'd3;
            end
            rnd_pass_mask();
            cyc();
        end
        rd_check(1'b0, 0, 1, 3);
        rd_check(1'b0, 1, 2, 0);
        rd_check(1'b0, 3, 3, 0);

        tag = "midreset";
        ifa.btn = 4'b0100;
        ifb.btn = 5'b00001;
        for (int i = 0; i < 10; i++) begin
            tick_b = ((i % 3) == 0);
            cyc();
        end
        tick_b = 1'b0;
        #2 resetn = 1'b0;
        #1;
        check("midreset_async_out_a", 32'(ifa.out), 0);
        check("midreset_async_out_b", 32'(ifb.out), 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rd_check(1'b0, 0, 0, 6);
        rd_check(1'b0, 1, 0, 6);
        resetn = 1'b1;

        tag = "refire";
        for (int i = 0; i < 20; i++) begin
            tick_b     = ((i % 5) == 4);
            ifa.btn[0] = 1'b1;
            cyc();
        end
        tick_b = 1'b0;
        @(negedge clk);
        check("sb_drain", 32'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
